intmatmul_sequencer: RTL

Sequencer that time-shares a single multiply-accumulate (MAC) datapath across all rows of a pVectorSize x pVectorSize integer matrix-vector product. It replaces the fully parallel dot-product array in low-area IntMatMul builds. It walks matrix and vector storage through a read port with fixed 1-cycle latency and writes one result word per row into a result buffer. Host control uses a Start/Busy/Done handshake, and a Hold input stalls read issue for external arbitration.

---
 rtl/intmatmul_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/intmatmul_sequencer.sv
// Time-shared MAC sequencer for an N x N integer matrix-vector product.
// Streams one row at a time through a single truncating MAC and writes one result per row.
module intmatmul_sequencer #(
   parameter int pVectorSize = 8,
   parameter int pWordSize   = 8,
   parameter int pIdxWidth   = 3
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic                   Hold,
   output logic                   Busy,
   output logic                   Done,
   output logic                   memRdEn,
   output logic [2*pIdxWidth-1:0] matAddr,
   output logic [pIdxWidth-1:0]   vecAddr,
   input  logic [pWordSize-1:0]   matData,
   input  logic [pWordSize-1:0]   vecData,
   output logic                   resWrEn,
   output logic [pIdxWidth-1:0]   resAddr,
   output logic [pWordSize-1:0]   resData
);

   localparam logic [pIdxWidth-1:0] lastIdx = pIdxWidth'(pVectorSize - 1);

   typedef enum logic [2:0] {
      sIdle,
      sRun,
      sDrain,
      sWrite,
      sDone
   } stateT;

   stateT                 state;
   stateT                 nextState;
   logic [pIdxWidth-1:0]  row;
   logic [pIdxWidth-1:0]  col;
   logic [pWordSize-1:0]  acc;
   logic [pWordSize-1:0]  prodLo;
   logic                  validD;

   // Product truncated to the word size, matching the parallel datapath.
   assign prodLo = pWordSize'(matData * vecData);

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= sIdle;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; Start only matters in IDLE, Hold only in RUN.
   always_comb begin
      nextState = state;
      unique case (state)
         sIdle:   if (Start) nextState = sRun;
         sRun:    if (!Hold && col == lastIdx) nextState = sDrain;
         sDrain:  nextState = sWrite;
         sWrite:  nextState = (row == lastIdx) ? sDone : sRun;
         sDone:   nextState = sIdle;
         default: nextState = sIdle;
      endcase
   end

   // Output decode; everything idles at zero outside its active state.
   always_comb begin
      Busy    = 1'b0;
      Done    = 1'b0;
      memRdEn = 1'b0;
      matAddr = '0;
      vecAddr = '0;
      resWrEn = 1'b0;
      resAddr = '0;
      resData = '0;
      unique case (state)
         sRun: begin
            Busy    = 1'b1;
            memRdEn = !Hold;
            matAddr = {row, col};
            vecAddr = col;
         end
         sDrain: begin
            Busy = 1'b1;
         end
         sWrite: begin
            Busy    = 1'b1;
            resWrEn = 1'b1;
            resAddr = row;
            resData = acc;
         end
         sDone: begin
            Done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Row/column walk, read-valid pipeline and wrapping accumulator.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         row    <= '0;
         col    <= '0;
         acc    <= '0;
         validD <= 1'b0;
      end else begin
         validD <= memRdEn;
         if (state == sIdle && Start) begin
            row <= '0;
            col <= '0;
            acc <= '0;
         end else begin
            if (memRdEn) begin
               col <= (col == lastIdx) ? '0 : col + 1'b1;
            end
            if (state == sWrite) begin
               acc <= '0;
               row <= (row == lastIdx) ? '0 : row + 1'b1;
            end else if (validD) begin
               acc <= acc + prodLo;
            end
         end
      end
   end

endmodule
